// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants, width defaults and FSM state type for the ALU issuer
package alu_pkg;

    localparam int ALU_DATA_W = 12;
    localparam int ALU_OP_W   = 3;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_UMUL = 3'b011;
    localparam logic [2:0] OP_SMUL = 3'b100;
    localparam logic [2:0] OP_FADD = 3'b101;
    localparam logic [2:0] OP_FMUL = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO holding packed {op, a, b} entries
// Head entry is presented combinationally; pointers wrap modulo DEPTH (power of two).
module alu_cmd_fifo #(
    parameter int W     = 27,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - queues ALU commands, drives them for SETTLE cycles and returns results
// Defining ALU_ISSUE_STATS_EN adds saturating cnt_done/cnt_err response counters.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OP_W-1:0]   rsp_op,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic              busy
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]       cnt_done,
    output logic [7:0]        cnt_err
`endif
);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CMD_W = OP_W + 2 * DATA_W;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [OP_W-1:0]     r_alu_op;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_rsp_op;
    logic [DATA_W-1:0]   r_rsp_result;
    logic                r_rsp_err;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [$clog2(DEPTH):0] w_fifo_count;
    logic [CMD_W-1:0]    w_head;
    logic [OP_W-1:0]     w_head_op;
    logic [DATA_W-1:0]   w_head_a;
    logic [DATA_W-1:0]   w_head_b;
    logic                w_head_undef;
    logic                w_pop;

    alu_cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .din   ({cmd_op, cmd_a, cmd_b}),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign {w_head_op, w_head_a, w_head_b} = w_head;
    assign w_head_undef = (w_head_op == OP_W'(OP_NONE));

    // A response handshake in HOLD frees the issuer in the same cycle, so the next pop needs no bubble.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && rsp_ready));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_pop)
                    w_state_nxt = w_head_undef ? ST_HOLD : ST_DRIVE;
                else if ((r_state == ST_HOLD) && rsp_ready)
                    w_state_nxt = ST_IDLE;
            end
            ST_DRIVE: begin
                if (r_cnt == '0) w_state_nxt = ST_HOLD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_op     <= '0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                if (w_head_undef) begin
                    r_rsp_op     <= OP_W'(OP_NONE);
                    r_rsp_result <= '0;
                    r_rsp_err    <= 1'b1;
                end else begin
                    r_alu_op <= w_head_op;
                    r_alu_a  <= w_head_a;
                    r_alu_b  <= w_head_b;
                    r_cnt    <= CNT_W'(SETTLE - 1);
                end
            end else if (r_state == ST_DRIVE) begin
                if (r_cnt == '0) begin
                    r_rsp_op     <= r_alu_op;
                    r_rsp_result <= alu_result;
                    r_rsp_err    <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign cmd_ready  = !w_fifo_full;
    assign alu_opcode = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_valid  = (r_state == ST_HOLD);
    assign rsp_op     = r_rsp_op;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;
    assign busy       = (w_fifo_count != '0) || (r_state != ST_IDLE);

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] r_cnt_done;
    logic [7:0]  r_cnt_err;
    logic        w_rsp_fire;

    assign w_rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_done <= '0;
            r_cnt_err  <= '0;
        end else if (w_rsp_fire) begin
            if (r_cnt_done != '1) r_cnt_done <= r_cnt_done + 16'd1;
            if (r_rsp_err && (r_cnt_err != '1)) r_cnt_err <= r_cnt_err + 8'd1;
        end
    end

    assign cnt_done = r_cnt_done;
    assign cnt_err  = r_cnt_err;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed bench for alu_issue_ctrl with a behavioural ALU stand-in
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DATA_W = 12;
    localparam int OP_W   = 3;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [OP_W-1:0]   rsp_op;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_err;
    logic              busy;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0]       cnt_done;
    logic [7:0]        cnt_err;
`endif

    alu_issue_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_op     (rsp_op),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .cnt_done   (cnt_done),
        .cnt_err    (cnt_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] alu_model(input logic [2:0] op, input logic [11:0] a,
                                              input logic [11:0] b);
        logic signed [23:0] sp;
        logic [23:0]        up;
        up = 24'(a) * 24'(b);
        sp = 24'($signed(a)) * 24'($signed(b));
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_UMUL: return up[11:0];
            OP_SMUL: return sp[11:0];
            OP_FADD: return a ^ b;
            OP_FMUL: return a & b;
            OP_CMP:  return (a == b) ? 12'h000 : ((a > b) ? 12'h001 : 12'hFFF);
            default: return 12'hBAD;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_opcode, alu_a, alu_b);

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] exp_res;
        logic        exp_err;
        logic [11:0] exp_alu_a;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int idx;
        int last_cyc;
        int bad;
        int waited;
        logic [11:0] q_exp[5];

        vecs[0] = '{OP_ADD,  12'h0DF, 12'h0B6, 12'h195, 1'b0, 12'h0DF};
        vecs[1] = '{OP_SUB,  12'h0DF, 12'h0B6, 12'h029, 1'b0, 12'h0DF};
        vecs[2] = '{OP_UMUL, 12'h007, 12'h005, 12'h023, 1'b0, 12'h007};
        vecs[3] = '{OP_NONE, 12'h123, 12'h456, 12'h000, 1'b1, 12'h007};
        vecs[4] = '{OP_SMUL, 12'h007, 12'hFFB, 12'hFDD, 1'b0, 12'h007};
        vecs[5] = '{OP_CMP,  12'h160, 12'h160, 12'h000, 1'b0, 12'h160};
        vecs[6] = '{OP_ADD,  12'hFFF, 12'h001, 12'h000, 1'b0, 12'hFFF};
        q_exp = '{12'h195, 12'h029, 12'h023, 12'hFDD, 12'h000};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_cmd_ready",  cmd_ready,  1);
        check("rst_rsp_valid",  rsp_valid,  0);
        check("rst_busy",       busy,       0);
        check("rst_alu_opcode", alu_opcode, 0);
        check("rst_alu_a",      alu_a,      0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_err",    rsp_err,    0);
        rst_n = 1'b1;
        tick();

        // single-command latency for each vector
        for (int i = 0; i < 7; i++) begin
            push_cmd(vecs[i].op, vecs[i].a, vecs[i].b);
            lat = vecs[i].exp_err ? 1 : SETTLE + 1;
            for (int k = 1; k < lat; k++) begin
                tick();
                check($sformatf("v%0d_early_valid", i), rsp_valid, 0);
                if (k == 1) check($sformatf("v%0d_alu_op", i), alu_opcode, vecs[i].op);
            end
            tick();
            check($sformatf("v%0d_valid", i),  rsp_valid,  1);
            check($sformatf("v%0d_result", i), rsp_result, vecs[i].exp_res);
            check($sformatf("v%0d_op", i),     rsp_op,     vecs[i].exp_err ? 3'b000 : vecs[i].op);
            check($sformatf("v%0d_err", i),    rsp_err,    vecs[i].exp_err);
            check($sformatf("v%0d_alu_a", i),  alu_a,      vecs[i].exp_alu_a);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check($sformatf("v%0d_done_valid", i), rsp_valid, 0);
            check($sformatf("v%0d_done_busy", i),  busy,      0);
        end

        // fill the FIFO behind a held response, then drain with rsp_ready high
        push_cmd(OP_ADD, 12'h0DF, 12'h0B6);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("q_ready%0d", i), cmd_ready, 1);
            push_cmd(vecs[(i < 2) ? i + 1 : i + 2].op, vecs[(i < 2) ? i + 1 : i + 2].a,
                     vecs[(i < 2) ? i + 1 : i + 2].b);
        end
        check("q_full_ready", cmd_ready, 0);
        check("q_busy",       busy,      1);
        rsp_ready = 1'b1;
        idx = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
            if (rsp_valid) begin
                check($sformatf("q_res%0d", idx), rsp_result, q_exp[idx]);
                if (idx > 0) check($sformatf("q_gap%0d", idx), cyc - last_cyc, SETTLE + 1);
                last_cyc = cyc;
                idx++;
            end
            tick();
        end
        check("q_resp_count", idx, 5);
        rsp_ready = 1'b0;
        tick();
        check("q_idle_busy", busy, 0);

        // backpressure: response must stay stable and nothing is popped
        push_cmd(OP_ADD, 12'h100, 12'h023);
        push_cmd(OP_SUB, 12'h050, 12'h060);
        waited = 0;
        while (!rsp_valid && waited < 10) begin
            tick();
            waited++;
        end
        check("bp_first_valid", rsp_valid, 1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_result !== 12'h123 || alu_a !== 12'h100 ||
                alu_b !== 12'h023 || alu_opcode !== OP_ADD)
                bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_result", rsp_result, 12'h123);
        check("bp_busy",   busy,       1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        check("bp_second_early", rsp_valid, 0);
        tick();
        check("bp_second_valid",  rsp_valid,  1);
        check("bp_second_result", rsp_result, 12'hFF0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // reset while one command is in DRIVE and three are queued
        push_cmd(OP_ADD, 12'h001, 12'h001);
        push_cmd(OP_ADD, 12'h011, 12'h001);
        push_cmd(OP_SUB, 12'h022, 12'h001);
        push_cmd(OP_UMUL, 12'h033, 12'h002);
        push_cmd(OP_CMP, 12'h044, 12'h003);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("mr_drive_alu_a", alu_a, 12'h011);
        check("mr_drive_busy",  busy,  1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_rsp_valid",  rsp_valid,  0);
        check("mr_cmd_ready",  cmd_ready,  1);
        check("mr_busy",       busy,       0);
        check("mr_alu_a",      alu_a,      0);
        check("mr_alu_opcode", alu_opcode, 0);
        check("mr_rsp_result", rsp_result, 0);
        tick();
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("mr_quiet_after", bad, 0);

`ifdef ALU_ISSUE_STATS_EN
        check("st_reset_done", cnt_done, 0);
        push_cmd(OP_ADD, 12'h001, 12'h002);
        push_cmd(OP_NONE, 12'h123, 12'h000);
        push_cmd(OP_SUB, 12'h005, 12'h002);
        push_cmd(OP_CMP, 12'h005, 12'h002);
        repeat (20) tick();
        check("st_cnt_done", cnt_done, 4);
        check("st_cnt_err",  cnt_err,  1);
`endif
        rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential command issuer for the 12-bit combinational ALU: accepts (opcode, A, B) commands over a valid/ready handshake and buffers them in a small FIFO. It drives them one at a time onto the ALU operand/opcode inputs and holds them for a fixed settle window. It then captures the ALU result and returns it over a second valid/ready handshake. It is the initiator side of the ALU interface, replacing the bench-style "drive, wait #20, sample" sequence with synthesizable control.

## Interface
- DATA_W, 12, operand/result width
- OP_W, 3, opcode width
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- SETTLE, 2, cycles operands are held before result capture (≥1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept
- cmd_op  in  OP_W  opcode
- cmd_a, cmd_b  in  DATA_W  operands
- alu_opcode  out  OP_W  to ALU opcode
- alu_a, alu_b  out  DATA_W  to ALU operands
- alu_result  in  DATA_W  from ALU
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_op  out  OP_W  opcode of this response
- rsp_result  out  DATA_W  captured result
- rsp_err  out  1  opcode was 000 (undefined)
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Opcodes: 001 add, 010 sub, 011 unsigned mul, 100 signed mul, 101 FP add, 110 FP mul, 111 compare; 000 undefined.
- Push on cmd_valid && cmd_ready; cmd_ready = !full from the registered count (no same-cycle pass-through when full, even if popping).
- FSM states IDLE, DRIVE, HOLD.
- IDLE: if FIFO non-empty, pop head. Legal opcode → load alu_* registers, counter = SETTLE-1, go to DRIVE. Opcode 000 → leave alu_* unchanged, load rsp_result=0, rsp_err=1, go to HOLD.
- DRIVE: decrement counter. At 0, capture alu_result into rsp_result, rsp_op = alu_opcode, rsp_err=0, go to HOLD.
- HOLD: rsp_valid=1, rsp_* stable. On rsp_ready, go to IDLE, or pop directly into DRIVE/HOLD if FIFO is non-empty (back-to-back, no idle bubble).
- alu_* retain their last values outside DRIVE; the ALU sees no spurious opcode change.
- One command in flight; response order = command order.

## Timing
- Reset (async assert, sync release): state IDLE, FIFO empty, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_op=0, rsp_result=0, alu_opcode=0, alu_a=0, alu_b=0, busy=0.
- Latency, empty FIFO and idle: accept at edge E0, pop/drive at E1, capture at E(1+SETTLE), rsp_valid high after E(1+SETTLE). With SETTLE=2, valid after E3.
- Undefined opcode: rsp_valid high one edge after pop.
- Throughput with rsp_ready tied high: one response per SETTLE+1 cycles.
- Simultaneous push and pop when not full: both occur; count unchanged.
- FIFO pointers wrap modulo DEPTH.
- Reset mid-operation: in-flight and queued commands discarded; no response emitted.

## Configuration
- ALU_ISSUE_STATS_EN defined: adds outputs cnt_done[15:0] (responses handshaken) and cnt_err[7:0] (responses with rsp_err). Both saturate at all-ones and reset to 0.
- ALU_ISSUE_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package alu_pkg: opcode constants (OP_ADD…OP_CMP, OP_NONE=000), DATA_W/OP_W defaults, FSM state enum.
- Sub-module alu_cmd_fifo: parameterized synchronous FIFO (push/pop/full/empty/count), storing {op, a, b}.

## Test plan
- Add 0x0DF + 0x0B6, SETTLE=2, rsp_ready=1 -> rsp_valid after E3, rsp_result=0x195, rsp_op=001, rsp_err=0.
- Queue four commands back-to-back (sub 0x0DF−0x0B6, umul 7×5, smul 7×0xFFB, cmp 0x160 vs 0x160) -> cmd_ready drops after the 4th. Results are 0x029, 0x023, 0xFDD, 0x000 in order, spaced 3 cycles apart.
- Hold rsp_ready=0 for 10 cycles with 2 commands queued -> rsp_* stable, alu_* unchanged, no pop. Release -> second response 3 cycles later.
- Opcode 000 with A=0x123 -> rsp_result=0, rsp_err=1 one edge after pop, alu_* unchanged.
- Assert rst_n=0 during DRIVE with 3 queued -> all outputs at reset values immediately, no response after release, busy=0.
- With ALU_ISSUE_STATS_EN, run 3 legal and 1 undefined command -> cnt_done=4, cnt_err=1.
